tick_monitor: RTL

TICK_MONITOR -- requirements
Module: tick_monitor

---
 rtl/tick_monitor.sv | 111 +++++++++++
 1 files changed

// File: rtl/tick_monitor.sv
// Tick period monitor: measures rise-to-rise spacing of a divider strobe in
// clock-enabled cycles, flags missing ticks and reports lock on repeat periods.
module tick_monitor #(
  parameter int unsigned      CNT_W      = 26,
  parameter logic [CNT_W-1:0] MAX_PERIOD = 26'd20_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_CE,
  input  logic             i_tick,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_locked,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_d;
  logic             r_tick_q, r_tick_d;
  logic             have_prev_q, have_prev_d;
  logic             valid_d, timeout_d, locked_d;
  logic             rise;

  // A level held high yields a single rise; nothing is seen while CE is low.
  assign rise    = i_CE & i_tick & ~r_tick_q;
  assign o_state = state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_tick_q    <= 1'b0;
      have_prev_q <= 1'b0;
      o_period    <= '0;
      o_valid     <= 1'b0;
      o_timeout   <= 1'b0;
      o_locked    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_tick_q    <= r_tick_d;
      have_prev_q <= have_prev_d;
      o_period    <= period_d;
      o_valid     <= valid_d;
      o_timeout   <= timeout_d;
      o_locked    <= locked_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_tick_d    = r_tick_q;
    have_prev_d = have_prev_q;
    period_d    = o_period;
    valid_d     = 1'b0;
    timeout_d   = o_timeout;
    locked_d    = o_locked;
    if (i_CE) begin
      r_tick_d = i_tick;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_W'(1);
          end
        end
        MEASURE: begin
          // A rise on the saturation cycle still counts as a capture.
          if (rise) begin
            period_d    = cnt_q;
            valid_d     = 1'b1;
            cnt_d       = CNT_W'(1);
            locked_d    = (cnt_q == o_period) && have_prev_q;
            have_prev_d = 1'b1;
          end else if (cnt_q >= MAX_PERIOD) begin
            state_d     = TIMEOUT;
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            have_prev_d = 1'b0;
            cnt_d       = MAX_PERIOD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        TIMEOUT: begin
          cnt_d = MAX_PERIOD;
          if (rise) begin
            state_d   = MEASURE;
            timeout_d = 1'b0;
            cnt_d     = CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule
